snapshot_ctrl: RTL and testbench

Memory-mapped sequencer for the image-compressor snapshot path. It accepts snapshot requests from the CPU (control register) or the snapshot push-button. It waits for the VGA scan to reach the top-left compressor pixel, fires a one-cycle start to the compressor, tracks the scan until the last compressed pixel, then reports done/error through a status register and an optional interrupt. It replaces the ad-hoc request/progress flops in the top level and owns CPU addresses 0xC008–0xC009.

---
 rtl/snapshot_pkg.sv | 34 +++
 rtl/snapshot_ctrl_edge_det_fall.sv | 20 ++
 rtl/snapshot_ctrl.sv | 143 ++++++++++++++
 tb/tb_snapshot_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/snapshot_pkg.sv
// Shared types and constants for the snapshot sequencer: state encoding,
// CTRL/STAT bit positions and default register map.
package snapshot_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;

  typedef enum logic [1:0] {
    SNAP_IDLE    = ST_IDLE,
    SNAP_ARMED   = ST_ARMED,
    SNAP_CAPTURE = ST_CAPTURE
  } snap_state_t;

  localparam int unsigned CTRL_REQ_BIT    = 0;
  localparam int unsigned CTRL_IRQ_EN_BIT = 1;
  localparam int unsigned CTRL_ABORT_BIT  = 2;
  localparam int unsigned CTRL_BUSY_BIT   = 0;

  localparam int unsigned STAT_BUSY_BIT    = 0;
  localparam int unsigned STAT_DONE_BIT    = 1;
  localparam int unsigned STAT_TIMEOUT_BIT = 2;
  localparam int unsigned STAT_OVERRUN_BIT = 4;
  localparam int unsigned STAT_CNT_LSB     = 8;

  localparam int unsigned CNT_W = 8;
  localparam int unsigned TMO_W = 22;

  localparam logic [31:0] DEF_CTRL_ADDR      = 32'h0000_C008;
  localparam logic [31:0] DEF_STAT_ADDR      = 32'h0000_C009;
  localparam int unsigned DEF_LAST_COORD     = 223;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 4_000_000;

endpackage

// File: rtl/snapshot_ctrl_edge_det_fall.sv
// Falling-edge detector with a one-flop history; usable for any
// active-low, already-synchronized KEY input.
module edge_det_fall (
  input  logic clk,
  input  logic rst,
  input  logic i_sig_n,
  output logic o_fall_c
);

  logic r_prev;

  // History resets to the released (high) level so reset never fakes an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_prev <= 1'b1;
    else     r_prev <= i_sig_n;
  end

  assign o_fall_c = r_prev & ~i_sig_n;

endmodule

// File: rtl/snapshot_ctrl.sv
// Snapshot sequencer: CPU/button request -> wait for scan origin -> start
// compressor -> wait for last pixel -> done. Build with SNAP_TIMEOUT_EN for the watchdog.
module snapshot_ctrl
  import snapshot_pkg::*;
#(
  parameter int unsigned LAST_COORD     = DEF_LAST_COORD,
  parameter logic [31:0] CTRL_ADDR      = DEF_CTRL_ADDR,
  parameter logic [31:0] STAT_ADDR      = DEF_STAT_ADDR,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic        re,
  input  logic [31:0] wdata,
  input  logic        key_snap_n,
  input  logic [7:0]  pix_x,
  input  logic [7:0]  pix_y,
  output logic [31:0] rdata,
  output logic        sel,
  output logic        compress_start,
  output logic        busy,
  output logic        irq
);

  snap_state_t      r_state;
  logic             r_compress_start;
  logic             r_irq_en;
  logic             r_done;
  logic             r_timeout_err;
  logic             r_overrun;
  logic [CNT_W-1:0] r_snap_cnt;

  logic w_key_fall, w_ctrl_hit, w_stat_hit, w_ctrl_wr, w_stat_rd;
  logic w_abort, w_req, w_busy, w_at_origin, w_at_last, w_timeout;
  logic w_unused_wdata;

  edge_det_fall u_key_edge (
    .clk      (clk),
    .rst      (rst),
    .i_sig_n  (key_snap_n),
    .o_fall_c (w_key_fall)
  );

  assign w_ctrl_hit  = (addr == CTRL_ADDR);
  assign w_stat_hit  = (addr == STAT_ADDR);
  assign w_ctrl_wr   = we & w_ctrl_hit;
  assign w_stat_rd   = re & w_stat_hit;
  assign w_abort     = w_ctrl_wr & wdata[CTRL_ABORT_BIT];
  // Button and CPU requests merge into one; abort drops either.
  assign w_req       = ((w_ctrl_wr & wdata[CTRL_REQ_BIT]) | w_key_fall) & ~w_abort;
  assign w_busy      = (r_state != SNAP_IDLE);
  assign w_at_origin = (pix_x == 8'd0) && (pix_y == 8'd0);
  assign w_at_last   = (pix_x == 8'(LAST_COORD)) && (pix_y == 8'(LAST_COORD));
  assign w_unused_wdata = ^wdata[31:3];

`ifdef SNAP_TIMEOUT_EN
  logic [TMO_W-1:0] r_tmo_cnt;
  assign w_timeout = w_busy && (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                r_tmo_cnt <= '0;
    else if (r_state == SNAP_IDLE && w_req) r_tmo_cnt <= '0;
    else if (w_busy)                        r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
  end
`else
  localparam int unsigned TIMEOUT_UNUSED = TIMEOUT_CYCLES;
  assign w_timeout = 1'b0;
`endif

  // Sequencer state, status flags and snapshot counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state          <= SNAP_IDLE;
      r_compress_start <= 1'b0;
      r_irq_en         <= 1'b0;
      r_done           <= 1'b0;
      r_timeout_err    <= 1'b0;
      r_overrun        <= 1'b0;
      r_snap_cnt       <= '0;
    end else begin
      r_compress_start <= 1'b0;
      if (w_ctrl_wr) r_irq_en <= wdata[CTRL_IRQ_EN_BIT];
      if (w_stat_rd) begin
        r_done        <= 1'b0;
        r_timeout_err <= 1'b0;
        r_overrun     <= 1'b0;
      end
      if (w_req && w_busy) r_overrun <= 1'b1;
      case (r_state)
        SNAP_IDLE: begin
          if (w_req) r_state <= SNAP_ARMED;
        end
        SNAP_ARMED: begin
          if (w_abort) begin
            r_state <= SNAP_IDLE;
          end else if (w_timeout) begin
            r_state       <= SNAP_IDLE;
            r_timeout_err <= 1'b1;
          end else if (w_at_origin) begin
            r_state          <= SNAP_CAPTURE;
            r_compress_start <= 1'b1;
          end
        end
        SNAP_CAPTURE: begin
          if (w_abort) begin
            r_state <= SNAP_IDLE;
          end else if (w_timeout) begin
            r_state       <= SNAP_IDLE;
            r_timeout_err <= 1'b1;
          end else if (w_at_last) begin
            r_state    <= SNAP_IDLE;
            r_done     <= 1'b1;
            r_snap_cnt <= r_snap_cnt + CNT_W'(1);
          end
        end
        default: r_state <= SNAP_IDLE;
      endcase
    end
  end

  // Combinational register read mux.
  always_comb begin
    rdata = '0;
    if (w_ctrl_hit) begin
      rdata[CTRL_BUSY_BIT]   = w_busy;
      rdata[CTRL_IRQ_EN_BIT] = r_irq_en;
    end else if (w_stat_hit) begin
      rdata[STAT_BUSY_BIT]             = w_busy;
      rdata[STAT_DONE_BIT]             = r_done;
      rdata[STAT_TIMEOUT_BIT]          = r_timeout_err;
      rdata[STAT_OVERRUN_BIT]          = r_overrun;
      rdata[STAT_CNT_LSB +: CNT_W]     = r_snap_cnt;
    end
  end

  assign sel            = re & (w_ctrl_hit | w_stat_hit);
  assign compress_start = r_compress_start;
  assign busy           = w_busy;
  assign irq            = r_done & r_irq_en;

endmodule

// File: tb/tb_snapshot_ctrl.sv
// Directed scoreboard bench for snapshot_ctrl (watchdog checks follow SNAP_TIMEOUT_EN).
module tb_snapshot_ctrl;

  localparam logic [31:0] CTRL = 32'h0000_C008;
  localparam logic [31:0] STAT = 32'h0000_C009;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic        we, re;
  logic [31:0] wdata;
  logic        key_snap_n;
  logic [7:0]  pix_x, pix_y;
  logic [31:0] rdata;
  logic        sel, compress_start, busy, irq;

  int n_tests = 0;
  int n_fail  = 0;
  int n_starts = 0;

  string       tag_q[$];
  logic [31:0] exp_q[$];

  snapshot_ctrl #(
    .LAST_COORD     (223),
    .CTRL_ADDR      (CTRL),
    .STAT_ADDR      (STAT),
    .TIMEOUT_CYCLES (1000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .addr           (addr),
    .we             (we),
    .re             (re),
    .wdata          (wdata),
    .key_snap_n     (key_snap_n),
    .pix_x          (pix_x),
    .pix_y          (pix_y),
    .rdata          (rdata),
    .sel            (sel),
    .compress_start (compress_start),
    .busy           (busy),
    .irq            (irq)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (compress_start === 1'b1) n_starts++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "time limit");
  end

  task automatic expect_v(input string tag, input logic [31:0] exp);
    tag_q.push_back(tag);
    exp_q.push_back(exp);
  endtask

  task automatic check_v(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL sb_empty: observed %h, required a queued expectation", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s: observed %h required %h", t, obs, e);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    expect_v(tag, exp);
    check_v(obs);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cpu_wr(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; we = 1'b1;
    tick();
    we = 1'b0; wdata = '0;
  endtask

  task automatic set_pix(input logic [7:0] x, input logic [7:0] y);
    pix_x = x; pix_y = y;
  endtask

  // Combinational read is checked before the clearing edge.
  task automatic rd_chk(input string tag, input logic [31:0] a,
                        input logic [31:0] exp, input logic exp_sel);
    expect_v(tag, exp);
    expect_v({tag, "_sel"}, 32'(exp_sel));
    addr = a; re = 1'b1;
    #1;
    check_v(rdata);
    check_v(32'(sel));
    tick();
    re = 1'b0;
  endtask

  initial begin
    rst = 1'b1; addr = '0; we = 1'b0; re = 1'b0; wdata = '0;
    key_snap_n = 1'b1; pix_x = 8'd100; pix_y = 8'd50;
    tick(2);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_start", 32'(compress_start), 32'd0);
    chk("rst_irq",   32'(irq), 32'd0);
    chk("rst_sel",   32'(sel), 32'd0);
    rst = 1'b0;
    tick();
    rd_chk("stat_after_rst", STAT, 32'h0, 1'b1);
    rd_chk("unmapped_rd", 32'h0000_C00A, 32'h0, 1'b0);

    // basic capture
    cpu_wr(CTRL, 32'h1);
    chk("basic_armed_busy", 32'(busy), 32'd1);
    tick(3);
    chk("basic_no_early_start", 32'(compress_start), 32'd0);
    set_pix(8'd0, 8'd0);
    tick();
    chk("basic_start_pulse", 32'(compress_start), 32'd1);
    tick();
    chk("basic_start_width", 32'(compress_start), 32'd0);
    chk("basic_capture_busy", 32'(busy), 32'd1);
    set_pix(8'd10, 8'd10);
    tick(2);
    set_pix(8'd223, 8'd223);
    tick();
    chk("basic_done_busy", 32'(busy), 32'd0);
    chk("basic_irq_off", 32'(irq), 32'd0);
    rd_chk("basic_stat1", STAT, 32'h0000_0102, 1'b1);
    rd_chk("basic_stat2", STAT, 32'h0000_0100, 1'b1);
    chk("basic_start_count", 32'(n_starts), 32'd1);

    // interrupt via button
    cpu_wr(CTRL, 32'h2);
    rd_chk("ctrl_irq_en", CTRL, 32'h0000_0002, 1'b1);
    set_pix(8'd100, 8'd50);
    key_snap_n = 1'b0;
    tick();
    chk("key_armed", 32'(busy), 32'd1);
    tick();
    key_snap_n = 1'b1;
    tick();
    set_pix(8'd0, 8'd0);
    tick(2);
    set_pix(8'd223, 8'd223);
    tick();
    chk("irq_rise", 32'(irq), 32'd1);
    rd_chk("irq_stat", STAT, 32'h0000_0202, 1'b1);
    chk("irq_clear", 32'(irq), 32'd0);
    chk("irq_start_count", 32'(n_starts), 32'd2);

    // button + CPU request on the same cycle, then overrun during capture
    set_pix(8'd100, 8'd50);
    key_snap_n = 1'b0; addr = CTRL; wdata = 32'h3; we = 1'b1;
    tick();
    we = 1'b0; wdata = '0; key_snap_n = 1'b1;
    chk("dual_req_busy", 32'(busy), 32'd1);
    set_pix(8'd0, 8'd0);
    tick();
    chk("dual_start", 32'(compress_start), 32'd1);
    set_pix(8'd50, 8'd50);
    tick();
    cpu_wr(CTRL, 32'h3);
    rd_chk("overrun_stat", STAT, 32'h0000_0211, 1'b1);
    rd_chk("overrun_cleared", STAT, 32'h0000_0201, 1'b1);
    set_pix(8'd0, 8'd0);
    tick(2);
    chk("overrun_no_restart", 32'(n_starts), 32'd3);
    set_pix(8'd223, 8'd223);
    rd_chk("clear_vs_done_pre", STAT, 32'h0000_0201, 1'b1);
    chk("clear_vs_done_irq", 32'(irq), 32'd1);
    rd_chk("clear_vs_done_post", STAT, 32'h0000_0302, 1'b1);
    chk("clear_vs_done_irq_off", 32'(irq), 32'd0);

    // abort from ARMED
    cpu_wr(CTRL, 32'h0);
    set_pix(8'd100, 8'd50);
    cpu_wr(CTRL, 32'h1);
    chk("abort_armed", 32'(busy), 32'd1);
    cpu_wr(CTRL, 32'h5);
    chk("abort_idle", 32'(busy), 32'd0);
    set_pix(8'd0, 8'd0);
    tick(3);
    chk("abort_no_start", 32'(n_starts), 32'd3);
    rd_chk("abort_stat", STAT, 32'h0000_0300, 1'b1);
    cpu_wr(CTRL, 32'h5);
    chk("abort_req_dropped", 32'(busy), 32'd0);

    // watchdog
    set_pix(8'd5, 8'd5);
    cpu_wr(CTRL, 32'h1);
    chk("tmo_armed", 32'(busy), 32'd1);
    tick(999);
    chk("tmo_before_limit", 32'(busy), 32'd1);
    tick();
`ifdef SNAP_TIMEOUT_EN
    chk("tmo_fired_busy", 32'(busy), 32'd0);
    rd_chk("tmo_stat", STAT, 32'h0000_0304, 1'b1);
`else
    chk("tmo_none_busy", 32'(busy), 32'd1);
    tick(200);
    chk("tmo_none_still_busy", 32'(busy), 32'd1);
    rd_chk("tmo_none_stat", STAT, 32'h0000_0301, 1'b1);
    cpu_wr(CTRL, 32'h4);
    chk("tmo_none_abort", 32'(busy), 32'd0);
`endif

    // request while done=1 is accepted, then reset mid-capture
    set_pix(8'd100, 8'd50);
    cpu_wr(CTRL, 32'h3);
    set_pix(8'd0, 8'd0);
    tick();
    set_pix(8'd223, 8'd223);
    tick();
    chk("pre_rst_irq", 32'(irq), 32'd1);
    set_pix(8'd100, 8'd50);
    cpu_wr(CTRL, 32'h3);
    chk("done_req_busy", 32'(busy), 32'd1);
    chk("done_req_irq_held", 32'(irq), 32'd1);
    set_pix(8'd0, 8'd0);
    tick();
    chk("pre_rst_start", 32'(compress_start), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_start", 32'(compress_start), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_irq", 32'(irq), 32'd0);
    tick(2);
    rst = 1'b0;
    tick();
    rd_chk("post_rst_stat", STAT, 32'h0, 1'b1);
    rd_chk("post_rst_ctrl", CTRL, 32'h0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
